// File: rtl/function_bist_pkg.sv
// Shared types and constants for the function BIST engine.
// Build option: FUNCTION_BIST_FAIL_CAP_EN adds first-fail vector capture.
package function_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_IN_DEF = 5;
  localparam int NUM_VEC = 2 ** NUM_IN_DEF;

  // bit[i] is f for vector i; default is the 5-input XOR
  localparam logic [NUM_VEC-1:0] GOLDEN_DEF = 32'h9669_6996;

endpackage

// File: rtl/bist_settle_timer.sv
// Settle-time counter for the function BIST; reloaded by the FSM per vector.
// Flags expiry once the vector has been held for SETTLE_CYC cycles.
module bist_settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/function_bist.sv
// Built-in self test for the 5-input function block: sweeps all vectors.
// Build option: FUNCTION_BIST_FAIL_CAP_EN adds the fail_vec output.
module function_bist
  import function_bist_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int SETTLE_CYC = 2,
  parameter logic [2**NUM_IN-1:0] GOLDEN = GOLDEN_DEF,
  parameter int ERR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [NUM_IN-1:0] vec_out,
  input  logic              dut_f,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef FUNCTION_BIST_FAIL_CAP_EN
  output logic [NUM_IN-1:0] fail_vec,
`endif
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int NV = 2 ** NUM_IN;
  localparam logic [NUM_IN-1:0] LAST_VEC = NUM_IN'(NV - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] vec_q, vec_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic              expired;
  logic              mismatch;
`ifdef FUNCTION_BIST_FAIL_CAP_EN
  logic [NUM_IN-1:0] fv_q, fv_d;
`endif

  bist_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .expired(expired)
  );

  assign mismatch = dut_f ^ GOLDEN[vec_q];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef FUNCTION_BIST_FAIL_CAP_EN
    fv_d    = fv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = SETTLE;
`ifdef FUNCTION_BIST_FAIL_CAP_EN
          fv_d    = '0;
`endif
        end
      end
      SETTLE: begin
        if (expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
`ifdef FUNCTION_BIST_FAIL_CAP_EN
          // err_q never returns to zero mid-run, so it marks the first fail
          if (err_q == '0) begin
            fv_d = vec_q;
          end
`endif
        end
        if (vec_q == LAST_VEC) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FUNCTION_BIST_FAIL_CAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q <= '0;
    end else begin
      fv_q <= fv_d;
    end
  end

  assign fail_vec = fv_q;
`endif

  assign vec_out = vec_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
